// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: trace start/stop sequencing for the trace debugger encoder.
//
// Moves the encoder through IDLE -> START -> TRACE -> STOP -> IDLE:
//   START  requests a start/sync control packet (pkt_type_o=0) and waits for its handshake.
//   TRACE  allows instruction packets (trace_enable_o=1).
//   STOP   waits for the packet buffer to drain, then requests a stop packet (pkt_type_o=1).
// The encoder clock gate stays enabled while the FSM is out of IDLE, and for GATE_DELAY
// cycles after it returns there.
//
// Optional feature (compile-time macro TRDB_STOP_TIMEOUT_EN): bounds the time spent in STOP
// waiting for fifo_empty_i to STOP_TIMEOUT cycles. The stop packet is then sent anyway and
// stop_timeout_o pulses for one cycle. Without the macro the timeout counter does not
// exist and stop_timeout_o is tied low.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   trace_activated_i   user master enable
//   trace_req_on_i      start request pulse (trigger unit)
//   trace_req_off_i     stop request pulse (filter)
//   fifo_empty_i        downstream packet buffer empty
//   pkt_ready_i         packet emitter accepts the control packet
//   pkt_req_o           control packet request (valid)
//   pkt_type_o          0 = start/sync packet, 1 = stop packet
//   trace_enable_o      encoder may emit instruction packets
//   clk_en_o            encoder clock gate enable
//   state_o             current state: IDLE=0, START=1, TRACE=2, STOP=3
//   stop_timeout_o      one-cycle pulse when STOP is left by timeout

module trdb_trace_ctrl #(
    parameter int unsigned STOP_TIMEOUT = 16,
    parameter int unsigned GATE_DELAY   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trace_activated_i,
    input  logic       trace_req_on_i,
    input  logic       trace_req_off_i,
    input  logic       fifo_empty_i,
    input  logic       pkt_ready_i,
    output logic       pkt_req_o,
    output logic       pkt_type_o,
    output logic       trace_enable_o,
    output logic       clk_en_o,
    output logic [1:0] state_o,
    output logic       stop_timeout_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StTrace = 2'd2,
        StStop  = 2'd3
    } state_e;

    localparam int unsigned TailW = (GATE_DELAY > 0) ? $clog2(GATE_DELAY + 1) : 1;

    if (STOP_TIMEOUT == 0) begin : g_bad_stop_timeout
        $error("trdb_trace_ctrl: STOP_TIMEOUT must be at least 1");
    end

    state_e           state_q, state_d;
    logic             pend_stop_q, pend_stop_d;
    logic             pkt_req_q, pkt_req_d;
    logic             pkt_type_q, pkt_type_d;
    logic             trace_en_q, trace_en_d;
    logic             clk_en_q, clk_en_d;
    logic             stop_to_q, stop_to_d;
    logic [TailW-1:0] tail_q, tail_d;
    logic             stop_cond;
    logic             timeout_hit;

`ifdef TRDB_STOP_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(STOP_TIMEOUT + 1);

    logic [CntW-1:0] stop_cnt_q, stop_cnt_d;

    // Counts cycles spent in STOP; zero on the first STOP cycle, saturates at STOP_TIMEOUT.
    always_comb begin
        stop_cnt_d = '0;
        if (state_q == StStop) begin
            stop_cnt_d = stop_cnt_q;
            if (stop_cnt_q != CntW'(STOP_TIMEOUT)) begin
                stop_cnt_d = stop_cnt_q + 1'b1;
            end
        end
    end

    // The last of STOP_TIMEOUT cycles without fifo_empty_i has elapsed.
    assign timeout_hit = (stop_cnt_q == CntW'(STOP_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A stop can be requested either by the filter or by the user dropping the enable.
    assign stop_cond = trace_req_off_i | ~trace_activated_i;

    always_comb begin
        state_d     = state_q;
        pend_stop_d = pend_stop_q;
        pkt_req_d   = pkt_req_q;
        tail_d      = tail_q;
        stop_to_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tail_q != '0) begin
                    tail_d = tail_q - 1'b1;
                end
                if (trace_req_on_i && trace_activated_i && !trace_req_off_i) begin
                    state_d     = StStart;
                    pkt_req_d   = 1'b1;
                    pend_stop_d = 1'b0;
                    tail_d      = '0;  // a restart cancels the gate tail
                end
            end
            StStart: begin
                if (stop_cond) begin
                    pend_stop_d = 1'b1;
                end
                if (pkt_ready_i) begin
                    pkt_req_d   = 1'b0;
                    pend_stop_d = 1'b0;
                    // A stop seen at any point in START, including this cycle, skips TRACE.
                    state_d     = (pend_stop_q || stop_cond) ? StStop : StTrace;
                end
            end
            StTrace: begin
                // trace_req_on_i is ignored here, so off always wins over a coincident on.
                if (stop_cond) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (pkt_req_q) begin
                    if (pkt_ready_i) begin
                        pkt_req_d = 1'b0;
                        state_d   = StIdle;
                        tail_d    = TailW'(GATE_DELAY);
                    end
                end else if (fifo_empty_i) begin
                    pkt_req_d = 1'b1;
                end else if (timeout_hit) begin
                    pkt_req_d = 1'b1;
                    stop_to_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // pkt_type only changes on state changes, which never happen while a request waits.
        pkt_type_d = (state_d == StStop);
        trace_en_d = (state_d == StTrace);
        clk_en_d   = (state_d != StIdle) || (tail_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pend_stop_q <= 1'b0;
            pkt_req_q   <= 1'b0;
            pkt_type_q  <= 1'b0;
            trace_en_q  <= 1'b0;
            clk_en_q    <= 1'b0;
            stop_to_q   <= 1'b0;
            tail_q      <= '0;
`ifdef TRDB_STOP_TIMEOUT_EN
            stop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_stop_q <= pend_stop_d;
            pkt_req_q   <= pkt_req_d;
            pkt_type_q  <= pkt_type_d;
            trace_en_q  <= trace_en_d;
            clk_en_q    <= clk_en_d;
            stop_to_q   <= stop_to_d;
            tail_q      <= tail_d;
`ifdef TRDB_STOP_TIMEOUT_EN
            stop_cnt_q  <= stop_cnt_d;
`endif
        end
    end

    assign state_o        = state_q;
    assign pkt_req_o      = pkt_req_q;
    assign pkt_type_o     = pkt_type_q;
    assign trace_enable_o = trace_en_q;
    // Open the gate one cycle early so the encoder is clocked on the cycle START is entered.
    // Masked by reset so every output is low while rst_ni is asserted.
    assign clk_en_o       = clk_en_q
                          | (rst_ni & (state_q == StIdle) & trace_req_on_i & trace_activated_i);
`ifdef TRDB_STOP_TIMEOUT_EN
    assign stop_timeout_o = stop_to_q;
`else
    assign stop_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Self-checking bench for trdb_trace_ctrl: directed scenarios followed by random stimulus,
// all compared cycle by cycle against a behavioural model of the trace control rules.

module tb_trdb_trace_ctrl;

    localparam int unsigned StopTo  = 16;
    localparam int unsigned GateDly = 4;
`ifdef TRDB_STOP_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       trace_activated_i;
    logic       trace_req_on_i;
    logic       trace_req_off_i;
    logic       fifo_empty_i;
    logic       pkt_ready_i;
    logic       pkt_req_o;
    logic       pkt_type_o;
    logic       trace_enable_o;
    logic       clk_en_o;
    logic [1:0] state_o;
    logic       stop_timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode plus ages measured in cycles.
    int m_state;      // 0 idle, 1 start, 2 trace, 3 stop
    bit m_pend;       // stop asked for while in start
    int m_stop_age;   // cycles already spent in stop
    bit m_stop_req;   // stop packet currently requested
    int m_idle_age;   // cycles since idle was entered
    bit m_to_pulse;

    // Values observed at the last output check.
    logic [1:0] obs_state;
    logic       obs_req;
    logic       obs_type;
    logic       obs_ten;
    logic       obs_clk_en;
    int         n_to_pulses;

    always #5 clk_i = ~clk_i;

    trdb_trace_ctrl #(
        .STOP_TIMEOUT(StopTo),
        .GATE_DELAY  (GateDly)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .trace_activated_i(trace_activated_i),
        .trace_req_on_i   (trace_req_on_i),
        .trace_req_off_i  (trace_req_off_i),
        .fifo_empty_i     (fifo_empty_i),
        .pkt_ready_i      (pkt_ready_i),
        .pkt_req_o        (pkt_req_o),
        .pkt_type_o       (pkt_type_o),
        .trace_enable_o   (trace_enable_o),
        .clk_en_o         (clk_en_o),
        .state_o          (state_o),
        .stop_timeout_o   (stop_timeout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_pend     = 1'b0;
        m_stop_age = 0;
        m_stop_req = 1'b0;
        m_idle_age = GateDly;
        m_to_pulse = 1'b0;
    endtask

    task automatic model_step(input bit on, input bit off, input bit act, input bit empty,
                              input bit ready);
        bit quit;
        quit = off || !act;
        m_to_pulse = 1'b0;
        case (m_state)
            0: begin
                if (m_idle_age < 1000) m_idle_age++;
                if (on && act && !off) begin
                    m_state = 1;
                    m_pend  = 1'b0;
                end
            end
            1: begin
                if (quit) m_pend = 1'b1;
                if (ready) begin
                    m_state    = m_pend ? 3 : 2;
                    m_stop_age = 0;
                    m_stop_req = 1'b0;
                end
            end
            2: begin
                if (quit) begin
                    m_state    = 3;
                    m_stop_age = 0;
                    m_stop_req = 1'b0;
                end
            end
            3: begin
                if (m_stop_req) begin
                    if (ready) begin
                        m_state    = 0;
                        m_idle_age = 0;
                    end
                end else if (empty) begin
                    m_stop_req = 1'b1;
                end else if (ToEn && (m_stop_age + 1 >= StopTo)) begin
                    m_stop_req = 1'b1;
                    m_to_pulse = 1'b1;
                end
                m_stop_age++;
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        bit exp_req;
        bit exp_clk_en;
        exp_req    = (m_state == 1) || (m_state == 3 && m_stop_req);
        exp_clk_en = (m_state != 0) || (m_idle_age < GateDly)
                   || (trace_req_on_i && trace_activated_i);
        obs_state  = state_o;
        obs_req    = pkt_req_o;
        obs_type   = pkt_type_o;
        obs_ten    = trace_enable_o;
        obs_clk_en = clk_en_o;
        if (stop_timeout_o === 1'b1) n_to_pulses++;
        check_eq("state", state_o, m_state);
        check_eq("pkt_req", pkt_req_o, exp_req);
        if (exp_req) check_eq("pkt_type", pkt_type_o, (m_state == 3));
        check_eq("trace_enable", trace_enable_o, (m_state == 2));
        check_eq("clk_en", clk_en_o, exp_clk_en);
        check_eq("stop_timeout", stop_timeout_o, m_to_pulse);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic cycle(input bit on, input bit off, input bit act, input bit empty,
                         input bit ready);
        @(negedge clk_i);
        trace_req_on_i    = on;
        trace_req_off_i   = off;
        trace_activated_i = act;
        fifo_empty_i      = empty;
        pkt_ready_i       = ready;
        #1;
        check_outputs();
        @(posedge clk_i);
        model_step(on, off, act, empty, ready);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 100 && m_state != 0; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pkt_req"}, pkt_req_o, 1'b0);
        check_eq({tag, "_trace_en"}, trace_enable_o, 1'b0);
        check_eq({tag, "_clk_en"}, clk_en_o, 1'b0);
        check_eq({tag, "_stop_to"}, stop_timeout_o, 1'b0);
        check_eq({tag, "_state"}, state_o, 2'd0);
    endtask

    initial begin
        int cnt;
        rst_ni            = 1'b0;
        trace_activated_i = 1'b0;
        trace_req_on_i    = 1'b0;
        trace_req_off_i   = 1'b0;
        fifo_empty_i      = 1'b0;
        pkt_ready_i       = 1'b0;
        n_to_pulses       = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Start: on at cycle 0, ready at cycle 2, TRACE from cycle 3.
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check_eq("start_state", obs_state, 2'd1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check_eq("trace_state", obs_state, 2'd2);
        check_eq("trace_en_on", obs_ten, 1'b1);

        // On and off together in TRACE: off wins.
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        check_eq("on_off_stop", obs_state, 2'd3);
        check_eq("stop_trace_en", obs_ten, 1'b0);
        cycle(0, 0, 1, 0, 0);
        check_eq("stop_pkt_req", obs_req, 1'b1);
        check_eq("stop_pkt_type", obs_type, 1'b1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check_eq("back_idle", obs_state, 2'd0);
        repeat (GateDly + 1) cycle(0, 0, 1, 0, 0);

        // Off during START, ready withheld for 5 cycles; request must hold, then STOP.
        cycle(1, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cnt = 0;
        repeat (5) begin
            cycle(0, 0, 1, 0, 0);
            if (obs_req === 1'b1 && obs_type === 1'b0) cnt++;
        end
        check_eq("start_req_hold", cnt, 5);
        n_to_pulses = 0;
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check_eq("pend_to_stop", obs_state, 2'd3);

        // Buffer never drains: timeout only when the feature is built in.
        repeat (20) cycle(0, 0, 1, 0, 0);
        check_eq("timeout_pulses", n_to_pulses, ToEn ? 1 : 0);
        check_eq("timeout_req", obs_req, ToEn);
        go_idle();

        // Gate tail length after returning to IDLE.
        cnt = 0;
        repeat (8) begin
            cycle(0, 0, 1, 0, 0);
            if (obs_clk_en === 1'b1) cnt++;
        end
        check_eq("tail_len", cnt, GateDly);

        // Restart in the middle of the tail.
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 1, 1, 0, 0);
        go_idle();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        check_eq("tail_restart_clk_en", obs_clk_en, 1'b1);
        cycle(0, 0, 1, 0, 0);
        check_eq("tail_restart_start", obs_state, 2'd1);
        check_eq("tail_restart_clk_en2", obs_clk_en, 1'b1);

        // Reset in STOP while the stop packet is requested.
        cycle(0, 0, 1, 0, 1);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        check_eq("pre_reset_req", obs_req, 1'b1);
        #3;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        cycle(0, 0, 1, 0, 0);
        check_eq("post_reset_state", obs_state, 2'd0);

        // Random traffic.
        repeat (3000) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trdb_trace_ctrl.md
TRDB_TRACE_CTRL -- requirements
Module: trdb_trace_ctrl

Interface
REQ-001 The block SHALL have parameter STOP_TIMEOUT, default 16: max cycles spent in STOP waiting for fifo_empty_i.
REQ-002 The block SHALL have parameter GATE_DELAY, default 4: cycles clk_en_o stays high after return to IDLE.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 trace_activated_i  in  1  user master enable.
REQ-006 trace_req_on_i  in  1  start request from trigger unit, single-cycle pulse.
REQ-007 trace_req_off_i  in  1  stop request from filter, single-cycle pulse.
REQ-008 fifo_empty_i  in  1  downstream packet buffer empty.
REQ-009 pkt_ready_i  in  1  packet emitter accepts control packet.
REQ-010 pkt_req_o  out  1  control packet request (valid).
REQ-011 pkt_type_o  out  1  0 = start/sync packet, 1 = stop packet.
REQ-012 trace_enable_o  out  1  encoder may emit instruction packets.
REQ-013 clk_en_o  out  1  enable for the encoder clock gate.
REQ-014 state_o  out  2  current state: IDLE=0, START=1, TRACE=2, STOP=3.
REQ-015 stop_timeout_o  out  1  one-cycle pulse when STOP is left by timeout.

Function
REQ-016 The FSM SHALL have states IDLE, START, TRACE and STOP, registered, with state_o driven directly from the state register.
REQ-017 From IDLE, the FSM SHALL enter START when trace_req_on_i=1, trace_activated_i=1 and trace_req_off_i=0; otherwise it SHALL stay in IDLE.
REQ-018 In START, the block SHALL drive pkt_req_o=1 with pkt_type_o=0.
REQ-019 In START, the block SHALL enter TRACE in the cycle after pkt_ready_i=1 is sampled.
REQ-020 Once pkt_req_o is asserted, it and pkt_type_o SHALL remain stable until pkt_ready_i=1 is sampled.
REQ-021 A trace_req_off_i pulse or trace_activated_i=0 during START SHALL be latched in a pending-stop flag.
REQ-022 On START handshake completion with the pending-stop flag set, the FSM SHALL go to STOP instead of TRACE.
REQ-023 trace_enable_o SHALL be 1 only in TRACE and SHALL be registered, rising the cycle TRACE is entered.
REQ-024 In TRACE, trace_req_off_i=1 or trace_activated_i=0 SHALL move the FSM to STOP next cycle.
REQ-025 Simultaneous trace_req_on_i and trace_req_off_i in TRACE SHALL result in STOP (off wins).
REQ-026 trace_req_on_i in TRACE or STOP SHALL be ignored.
REQ-027 In STOP, pkt_req_o SHALL stay 0 until fifo_empty_i=1 is sampled.
REQ-028 In STOP, after fifo_empty_i=1 is sampled, the block SHALL assert pkt_req_o=1 with pkt_type_o=1.
REQ-029 In STOP, on the stop-packet handshake the FSM SHALL return to IDLE.
REQ-030 A STOP-entry counter SHALL count cycles in STOP, saturating, and SHALL clear on entry to STOP.
REQ-031 clk_en_o SHALL be 1 in START, TRACE and STOP, and for GATE_DELAY cycles after entering IDLE.
REQ-032 clk_en_o SHALL also go high combinationally in IDLE when trace_req_on_i=1 and trace_activated_i=1.
REQ-033 A new trace_req_on_i during the GATE_DELAY tail SHALL restart tracing normally and cancel the tail.

Reset
REQ-034 On rst_ni=0, asynchronously: state=IDLE, pending-stop=0, counters=0, and pkt_req_o, trace_enable_o, clk_en_o, stop_timeout_o, state_o all 0.
REQ-035 Reset mid-handshake SHALL drop pkt_req_o immediately with no packet completion implied.

Configuration
REQ-036 With TRDB_STOP_TIMEOUT_EN defined, if fifo_empty_i is not seen within STOP_TIMEOUT cycles in STOP, the block SHALL issue the stop packet anyway.
REQ-037 With TRDB_STOP_TIMEOUT_EN defined, a timeout exit SHALL pulse stop_timeout_o for one cycle when the stop packet is requested.
REQ-038 Without TRDB_STOP_TIMEOUT_EN, STOP SHALL wait for fifo_empty_i indefinitely, the counter SHALL not be instantiated, and stop_timeout_o SHALL be tied 0.

Verification
REQ-039 Activated=1, on pulse at cycle 0, pkt_ready_i=1 at cycle 2 -> state START at 1, TRACE at 3, trace_enable_o=1 from cycle 3.
REQ-040 In TRACE, on and off pulsed same cycle -> STOP next cycle, trace_enable_o=0; fifo_empty_i=1 -> pkt_req_o=1, pkt_type_o=1 until ready, then IDLE.
REQ-041 Off pulse during START with pkt_ready_i held 0 for 5 cycles -> pkt_req_o stable for 5 cycles; after handshake -> STOP, never TRACE.
REQ-042 With macro defined, STOP_TIMEOUT=16, fifo_empty_i=0 -> stop packet requested after 16 cycles, stop_timeout_o pulses once; without macro -> remains in STOP.
REQ-043 Return to IDLE, GATE_DELAY=4 -> clk_en_o high exactly 4 more cycles; on pulse at tail cycle 2 -> clk_en_o stays high, START entered.
REQ-044 rst_ni asserted during STOP with pkt_req_o=1 -> all outputs 0 in the same cycle, state_o=0 after release.
